// File: rtl/piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
// piso_arb_ctrl : two-requester round-robin loader and frame qualifier for PISO
// Revision 1.0
// ============================================================================
module piso_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_data,
  output logic             piso_rst,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             ser_src,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int             BIT_W   = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic               ser_src_q,   ser_src_d;
  logic               last_src_q,  last_src_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic             frame_end;
  logic             can_load;
  logic             grant_any;
  logic             grant_idx;
  logic             handshake;
  logic [WIDTH-1:0] grant_data;

  // Arbitration: a tie goes to whoever did not win the previous frame.
  always_comb begin
    frame_end  = (state_q == SHIFT) && (bit_cnt_q == '0);
    can_load   = (state_q == IDLE) || frame_end;
    grant_any  = req0_valid || req1_valid;
    grant_idx  = (req0_valid && req1_valid) ? ~last_src_q : req1_valid;
    grant_data = grant_idx ? req1_data : req0_data;
    handshake  = rst && can_load && grant_any;
  end

  always_comb begin
    req0_ready = handshake && !grant_idx;
    req1_ready = handshake &&  grant_idx;
    piso_load  = handshake;
    piso_data  = handshake ? grant_data : '0;
    piso_rst   = ~rst;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ser_src_d   = ser_src_q;
    last_src_d  = last_src_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q == SHIFT) begin
      bit_cnt_d = bit_cnt_q - BIT_W'(1);
      if (frame_end) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = IDLE;
      end
    end

    // A load in the last-bit cycle overrides the return to IDLE.
    if (handshake) begin
      state_d    = SHIFT;
      bit_cnt_d  = BIT_MAX;
      ser_src_d  = grant_idx;
      last_src_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      ser_src_q   <= 1'b0;
      last_src_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_src_q   <= ser_src_d;
      last_src_q  <= last_src_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    ser_valid = (state_q == SHIFT);
    ser_first = (state_q == SHIFT) && (bit_cnt_q == BIT_MAX);
    ser_last  = frame_end;
    ser_src   = ser_src_q;
    busy      = (state_q == SHIFT);
    frame_cnt = frame_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_arb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_piso_arb_ctrl : scoreboard bench with attached PISO and abstract line model
// Revision 1.0
// ============================================================================
module tb_piso_arb_ctrl;
  localparam int W = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [W-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          piso_load;
  logic [W-1:0]  piso_data;
  logic          piso_rst;
  logic          ser_valid, ser_first, ser_last, ser_src, busy;
  logic [CW-1:0] frame_cnt;

  piso_arb_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .piso_load(piso_load), .piso_data(piso_data), .piso_rst(piso_rst),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
    .ser_src(ser_src), .busy(busy), .frame_cnt(frame_cnt)
  );

  // Shift register the controller drives: async clear, parallel load, MSB out.
  logic [W-1:0] piso_reg;
  logic         piso_out;
  always @(posedge clk or posedge piso_rst) begin
    if (piso_rst)       piso_reg <= '0;
    else if (piso_load) piso_reg <= piso_data;
    else                piso_reg <= {piso_reg[W-2:0], 1'b0};
  end
  assign piso_out = piso_reg[W-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         src;
    logic [W-1:0] word;
    int         hs;
  } exp_t;

  exp_t sb[$];
  int   m_ends[$];   // last serial cycle of each accepted frame
  int   m_cnt  = 0;
  int   m_last = 1;

  // Reference model: line occupancy by cycle arithmetic, grant by fairness rule.
  always @(negedge clk) begin
    int  g;
    bit  can, exp_valid;
    logic [W-1:0] exp_data;
    while (m_ends.size() > 0 && m_ends[0] < cyc) begin
      void'(m_ends.pop_front());
      m_cnt++;
    end
    exp_valid = (m_ends.size() > 0) && (m_ends[0] - W < cyc);
    chk("frame_cnt", frame_cnt, m_cnt % (1 << CW));
    chk("ser_valid", ser_valid, exp_valid);
    chk("busy", busy, exp_valid);
    if (!rst) begin
      chk("rst_piso_rst", piso_rst, 1);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_load", piso_load, 0);
      m_ends.delete();
      sb.delete();
      m_cnt  = 0;
      m_last = 1;
    end else begin
      can = (m_ends.size() == 0) || (m_ends[0] == cyc);
      g = -1;
      if (req0_valid && req1_valid) g = 1 - m_last;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      if (!can) g = -1;
      exp_data = (g == 0) ? req0_data : (g == 1) ? req1_data : '0;
      chk("piso_rst", piso_rst, 0);
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      chk("piso_load", piso_load, g >= 0);
      chk("piso_data", piso_data, exp_data);
      if (g >= 0) begin
        sb.push_back('{g, exp_data, cyc});
        m_ends.push_back(cyc + W);
        m_last = g;
      end
    end
  end

  // Monitor: consumes expected frames whenever the line shows frame bits.
  int   k = 0;
  exp_t cur = '{0, '0, 0};
  always @(negedge clk) begin
    if (!rst) begin
      k = 0;
    end else if (ser_valid) begin
      if (k == 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got frame start expected none (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc, cur.hs + 1);
        end
      end
      chk("ser_first", ser_first, k == 0);
      chk("ser_last", ser_last, k == W - 1);
      chk("ser_src", ser_src, cur.src);
      chk("ser_bit", piso_out, cur.word[W-1-k]);
      k = (k + 1) % W;
    end else begin
      chk("frame_gap", k, 0);
      chk("idle_out", piso_out, 0);
      chk("idle_first", ser_first, 0);
      chk("idle_last", ser_last, 0);
    end
  end

  // Producers
  logic [W-1:0] q0[$], q1[$];
  int p0 = 100, p1 = 100;

  task automatic drive();
    req0_valid = (q0.size() > 0) && ($urandom_range(99) < p0);
    req1_valid = (q1.size() > 0) && ($urandom_range(99) < p1);
    req0_data  = req0_valid ? q0[0] : W'($urandom);
    req1_data  = req1_valid ? q1[0] : W'($urandom);
  endtask

  task automatic cycle();
    bit h0, h1;
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive();
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_ends.size() > 0) && guard < 3000) begin
      cycle();
      guard++;
    end
    chk("drain_timeout", guard < 3000, 1);
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0;    req1_data = '0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("reset_src", ser_src, 0);
    chk("reset_cnt", frame_cnt, 0);

    // Tie arbitration straight after reset: A,5,A,5 back-to-back.
    q0.push_back(4'hA); q0.push_back(4'hA);
    q1.push_back(4'h5); q1.push_back(4'h5);
    drain();
    chk("tie_cnt", frame_cnt, 4);

    // Single word.
    q0.push_back(4'b1011);
    drain();
    chk("single_cnt", frame_cnt, 5);

    // Hold-off: req1 raised two cycles into a req0 frame.
    q0.push_back(4'h9);
    cycle();
    cycle();
    q1.push_back(4'h6);
    drain();

    // Single requester repeats.
    q1.push_back(4'h3); q1.push_back(4'hE); q1.push_back(4'h7);
    drain();

    // Reset mid-frame at T+2, released at T+3, then a tie.
    q0.push_back(4'hC);
    cycle();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_valid", ser_valid, 0);
    q0.push_back(4'h1); q1.push_back(4'h8);
    drain();

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i % 3 == 0) q1.push_back(W'($urandom));
      else            q0.push_back(W'($urandom));
    end
    drain();
    chk("wrap_cnt", frame_cnt, 1);

    // Randomized traffic with withdrawn requests and garbage idle data.
    for (int r = 0; r < 4; r++) begin
      p0 = $urandom_range(100, 30);
      p1 = $urandom_range(100, 30);
      for (int i = 0; i < 30; i++) begin
        q0.push_back(W'($urandom));
        q1.push_back(W'($urandom));
      end
      drain();
    end

    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
